// File: rtl/regfile_write_port_if.sv
// Write-back request bundle for the register file write port.
//   RegWrite      : write enable from the write-back stage
//   WriteRegister : destination register index
//   WriteData     : data to write
// master = write-back stage (drives), slave = register file (receives).
interface regfile_write_port_if #(
   parameter int unsigned WIDTH = 64
);
   logic             RegWrite;
   logic [4:0]       WriteRegister;
   logic [WIDTH-1:0] WriteData;

   modport master (output RegWrite, output WriteRegister, output WriteData);
   modport slave  (input  RegWrite, input  WriteRegister, input  WriteData);
endinterface

// File: rtl/regfile_write_port.sv
// Write side of the 32 x WIDTH register file: 5:32 write decode, architectural
// storage with a hard-wired zero register, bit-major image for the read muxes,
// and a one-entry record of the most recent effective write for forwarding.
// Ports:
//   clk, reset    : clock; asynchronous active-low reset
//   wr            : write request (RegWrite / WriteRegister / WriteData)
//   regs_out      : regs_out[b][r] = bit b of register r
//   wr_onehot     : registered one-hot of the last decoded write enable
//   last_wr_valid : previous cycle performed an effective write
//   last_wr_addr  : index of that write
//   last_wr_data  : data of that write
module regfile_write_port #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned NREG     = 32,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic                       clk,
   input  logic                       reset,
   regfile_write_port_if.slave        wr,
   output logic [WIDTH-1:0][NREG-1:0] regs_out,
   output logic [NREG-1:0]            wr_onehot,
   output logic                       last_wr_valid,
   output logic [4:0]                 last_wr_addr,
   output logic [WIDTH-1:0]           last_wr_data
);

   localparam int unsigned AW = 5;

   logic [NREG-1:0] wr_en_c;
   logic            eff_wr_c;

   // One-hot write decode; index ZERO_REG still decodes (visible on wr_onehot)
   always_comb begin
      wr_en_c = '0;
      if (wr.RegWrite) begin
         wr_en_c = NREG'(1) << wr.WriteRegister;
      end
   end

   // A write to the zero register is discarded
   always_comb begin
      eff_wr_c = wr.RegWrite && (wr.WriteRegister != AW'(ZERO_REG));
   end

   // Per-register storage and bit-major fan-out
   for (genvar r = 0; r < int'(NREG); r++) begin : g_reg
      if (r == int'(ZERO_REG)) begin : g_zero
         // No storage: lane is constant zero, even during reset
         for (genvar b = 0; b < int'(WIDTH); b++) begin : g_bit
            assign regs_out[b][r] = 1'b0;
         end
      end else begin : g_store
         logic [WIDTH-1:0] q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               q <= '0;
            end else if (wr_en_c[r]) begin
               q <= wr.WriteData;
            end
         end

         for (genvar b = 0; b < int'(WIDTH); b++) begin : g_bit
            assign regs_out[b][r] = q[b];
         end
      end
   end

   // Decode visibility and last-write record for the forwarding unit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_onehot     <= '0;
         last_wr_valid <= 1'b0;
         last_wr_addr  <= '0;
         last_wr_data  <= '0;
      end else begin
         wr_onehot     <= wr_en_c;
         last_wr_valid <= eff_wr_c;
         if (eff_wr_c) begin
            last_wr_addr <= wr.WriteRegister;
            last_wr_data <= wr.WriteData;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: reset, table of single writes,
// sweep with back-to-back overwrite, and mid-operation asynchronous reset.
module tb_regfile_write_port;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned NREG  = 32;

   logic clk;
   logic clk_en;
   logic reset;

   logic [WIDTH-1:0][NREG-1:0] regs_out;
   logic [NREG-1:0]            wr_onehot;
   logic                       last_wr_valid;
   logic [4:0]                 last_wr_addr;
   logic [WIDTH-1:0]           last_wr_data;

   regfile_write_port_if #(.WIDTH(WIDTH)) wr_if ();

   regfile_write_port #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_REG(31)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr            (wr_if.slave),
      .regs_out      (regs_out),
      .wr_onehot     (wr_onehot),
      .last_wr_valid (last_wr_valid),
      .last_wr_addr  (last_wr_addr),
      .last_wr_data  (last_wr_data)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   int n_cmp;
   int n_err;
   logic [63:0] model [32];

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [63:0] data;
      logic        exp_valid;
      logic [4:0]  exp_addr;
      logic [63:0] exp_data;
      logic [31:0] exp_oh;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] lane(input logic [WIDTH-1:0][NREG-1:0] img, input int r);
      logic [63:0] v;
      for (int b = 0; b < 64; b++) v[b] = img[b][r];
      return v;
   endfunction

   task automatic chk_image(input string name);
      for (int r = 0; r < 32; r++) begin
         chk($sformatf("%s reg%0d", name, r), lane(regs_out, r), model[r]);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " regs_out"}, 64'(regs_out == '0), 64'd1);
      chk({name, " valid"}, 64'(last_wr_valid), 64'd0);
      chk({name, " addr"}, 64'(last_wr_addr), 64'd0);
      chk({name, " data"}, last_wr_data, 64'd0);
      chk({name, " onehot"}, 64'(wr_onehot), 64'd0);
   endtask

   task automatic do_write(input logic we, input logic [4:0] addr, input logic [63:0] data);
      @(negedge clk);
      wr_if.RegWrite      = we;
      wr_if.WriteRegister = addr;
      wr_if.WriteData     = data;
      @(posedge clk);
      #1;
      if (we && addr != 5'd31) model[addr] = data;
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      clk_en = 1'b0;
      for (int r = 0; r < 32; r++) model[r] = '0;

      vecs[0] = '{1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 32'h0000_0020};
      vecs[1] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd5, 64'hDEADBEEF_CAFEF00D, 32'h8000_0000};
      vecs[2] = '{1'b1, 5'd10, 64'h55,                1'b1, 5'd10, 64'h55,                32'h0000_0400};
      vecs[3] = '{1'b0, 5'd3,  64'h1234,              1'b0, 5'd10, 64'h55,                32'h0000_0000};
      vecs[4] = '{1'b1, 5'd0,  64'h77,                1'b1, 5'd0,  64'h77,                32'h0000_0001};

      // Reset with random write inputs and no clock edge
      reset               = 1'b0;
      wr_if.RegWrite      = 1'b1;
      wr_if.WriteRegister = 5'($urandom_range(0, 30));
      wr_if.WriteData     = {$urandom, $urandom};
      #2;
      chk_all_zero("reset_noclk");

      // Clock running under reset, then release with no write
      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      wr_if.RegWrite = 1'b0;
      reset          = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("post_release");

      // Table of single writes
      for (int i = 0; i < 5; i++) begin
         do_write(vecs[i].we, vecs[i].addr, vecs[i].data);
         chk($sformatf("vec%0d valid", i), 64'(last_wr_valid), 64'(vecs[i].exp_valid));
         chk($sformatf("vec%0d addr", i), 64'(last_wr_addr), 64'(vecs[i].exp_addr));
         chk($sformatf("vec%0d data", i), last_wr_data, vecs[i].exp_data);
         chk($sformatf("vec%0d onehot", i), 64'(wr_onehot), 64'(vecs[i].exp_oh));
         chk_image($sformatf("vec%0d", i));
      end
      chk("reg5 hand", lane(regs_out, 5), 64'hDEADBEEF_CAFEF00D);
      chk("reg31 hand", lane(regs_out, 31), 64'd0);
      chk("reg3 hand", lane(regs_out, 3), 64'd0);

      // Sweep r*0x0101.. into r = 0..30
      for (int r = 0; r < 31; r++) begin
         do_write(1'b1, 5'(r), 64'(r) * 64'h0101_0101_0101_0101);
      end
      chk("sweep last addr", 64'(last_wr_addr), 64'd30);
      chk("sweep onehot", 64'(wr_onehot), 64'h4000_0000);

      // Back-to-back overwrite of register 7
      do_write(1'b1, 5'd7, 64'hA);
      chk("ovw7 first", lane(regs_out, 7), 64'hA);
      do_write(1'b1, 5'd7, 64'hB);
      chk("ovw7 final", lane(regs_out, 7), 64'hB);
      chk("ovw7 valid", 64'(last_wr_valid), 64'd1);
      for (int r = 0; r < 31; r++) begin
         chk($sformatf("sweep reg%0d", r), lane(regs_out, r),
             (r == 7) ? 64'hB : 64'(r) * 64'h0101_0101_0101_0101);
      end
      chk("sweep reg31", lane(regs_out, 31), 64'd0);

      // Mid-operation reset between edges
      @(negedge clk);
      wr_if.RegWrite = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      for (int r = 0; r < 32; r++) model[r] = '0;

      // Write presented while reset releases: accepted on first edge after release
      wr_if.RegWrite      = 1'b1;
      wr_if.WriteRegister = 5'd1;
      wr_if.WriteData     = 64'h1111_2222_3333_4444;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel reg1 before edge", lane(regs_out, 1), 64'd0);
      @(posedge clk);
      #1;
      model[1] = 64'h1111_2222_3333_4444;
      chk("rel reg1 after edge", lane(regs_out, 1), 64'h1111_2222_3333_4444);
      chk("rel valid", 64'(last_wr_valid), 64'd1);
      chk("rel addr", 64'(last_wr_addr), 64'd1);
      chk("rel onehot", 64'(wr_onehot), 64'h0000_0002);
      chk_image("rel");

      // Valid holds one cycle only
      do_write(1'b0, 5'd1, 64'd0);
      chk("valid drop", 64'(last_wr_valid), 64'd0);
      chk("addr hold", 64'(last_wr_addr), 64'd1);
      chk("data hold", last_wr_data, 64'h1111_2222_3333_4444);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_write_port.md
# regfile_write_port

Write side of the 32 x 64-bit ARMv8 register file. Decodes a 5-bit write address into one-hot enables, holds the 32 architectural registers, and drives the full register contents to the read-port muxes. Register X31 (XZR) is hard-wired to zero. The block also holds a one-entry record of the most recent write, which the forwarding unit consumes. It sits at the write-back end of the 5-stage pipeline and feeds the read-port mux trees in the decode stage.

## Interface
Parameters:
- WIDTH, 64: register data width in bits.
- NREG, 32: number of registers. Fixed; must be 32.
- ZERO_REG, 31: index of the hard-wired zero register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- RegWrite  in  1  write enable from the write-back stage.
- WriteRegister  in  5  destination register index.
- WriteData  in  WIDTH  data to write.
- regs_out  out  [WIDTH-1:0][NREG-1:0]  bit-major register image. regs_out[b][r] is bit b of register r, so each bit lane feeds one 32:1 read mux directly.
- wr_onehot  out  32  registered one-hot copy of the last accepted write enable (debug/visibility).
- last_wr_valid  out  1  set when the previous cycle performed an effective write.
- last_wr_addr  out  5  index of that write.
- last_wr_data  out  WIDTH  data of that write.

## Operation
- Decoder: when RegWrite=1, the 5:32 one-hot decode of WriteRegister produces the enable for that register. When RegWrite=0, all enables are 0.
- Storage: 32 independent WIDTH-bit registers. A register loads WriteData on the rising edge when its enable is 1; otherwise it holds its value.
- Zero register:
  - Register ZERO_REG never loads.
  - Its regs_out lane is constant 0 at all times, including during reset.
  - A write to index 31 is discarded: no storage change, last_wr_valid=0, and wr_onehot is still updated to the decoded value (bit 31).
- Effective write: RegWrite=1 and WriteRegister != 31.
- Last-write record, updated every rising edge:
  - last_wr_valid <= effective write.
  - When the write is effective, last_wr_addr/last_wr_data load WriteRegister/WriteData. Otherwise they hold their previous values.
- Reset (reset=0):
  - Asynchronously clears all storage, wr_onehot, last_wr_valid, last_wr_addr and last_wr_data to 0.
  - All outputs read 0 while reset is held.
  - A write presented in the same cycle that reset deasserts is accepted on the first rising edge after deassertion only.
- Bit-major packing: regs_out[b][r] = reg_r[b] for every b in 0..63 and r in 0..31. No reordering and no inversion.
- No read/write conflict logic inside this block. Read-after-write within a cycle is resolved by the forwarding unit using the last_wr_* outputs.

## Timing
- Write latency: 1 cycle. The value presented with RegWrite=1 at edge N appears on regs_out immediately after edge N.
- last_wr_* become valid after the same edge N and hold for exactly one cycle unless another effective write follows.
- Back-to-back writes to the same register: each edge overwrites; the last one wins.
- regs_out is a direct register output with no combinational path from the write inputs.
- Reset is asynchronous: outputs go to 0 with no clock edge required.

## Test plan
- Reset: drive reset=0 with random write inputs and no clock edge -> every regs_out bit = 0, last_wr_valid=0, wr_onehot=0. Release reset -> all still 0 before the first write.
- Single write: RegWrite=1, WriteRegister=5, WriteData=64'hDEADBEEF_CAFEF00D, one edge:
  - regs_out[b][5] equals bit b of the data for all b; all other lanes stay 0.
  - last_wr_valid=1, last_wr_addr=5, wr_onehot=32'h0000_0020.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to index 31 -> lane 31 stays 0, last_wr_valid=0, last_wr_addr/data unchanged, wr_onehot=32'h8000_0000.
- Disabled write: RegWrite=0, WriteRegister=3, data=64'h1234 -> register 3 unchanged, last_wr_valid falls to 0 one cycle after the prior write.
- Sweep: write value r*64'h0101_0101_0101_0101 to r=0..30 on consecutive edges:
  - Every register holds its value afterwards.
  - Overwrite register 7 twice back-to-back (64'hA then 64'hB) -> final value 64'hB.
- Mid-operation reset: after the sweep, pulse reset low between edges -> all lanes and last_wr_* drop to 0 immediately. The next write to register 1 succeeds on the first edge after release.
